// File: rtl/mem_bist_if.sv
// Bus between the BIST initiator and its RAM/controller side.
// Optional first-error log signals are present only when MEM_BIST_ERR_LOG_EN is defined.
interface mem_bist_if #(
  parameter int DW = 6,
  parameter int AW = 5
);
  logic          start;
  logic [DW-1:0] seed;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
`ifdef MEM_BIST_ERR_LOG_EN
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
  logic          first_err_vld;

  modport master (
    input  start, seed, rd_data,
    output wr_en, wr_addr, wr_data, rd_addr, busy, done, pass, err_count,
           first_err_addr, first_err_data, first_err_vld
  );
  modport slave (
    output start, seed, rd_data,
    input  wr_en, wr_addr, wr_data, rd_addr, busy, done, pass, err_count,
           first_err_addr, first_err_data, first_err_vld
  );
`else
  modport master (
    input  start, seed, rd_data,
    output wr_en, wr_addr, wr_data, rd_addr, busy, done, pass, err_count
  );
  modport slave (
    output start, seed, rd_data,
    input  wr_en, wr_addr, wr_data, rd_addr, busy, done, pass, err_count
  );
`endif
endinterface

// File: rtl/mem_bist_initiator.sv
// Write-sweep then read-back-sweep RAM tester with mismatch counting.
// Define MEM_BIST_ERR_LOG_EN to add first-mismatch address/data capture.
module mem_bist_initiator #(
  parameter int DW    = 6,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic      clk,
  input  logic      rst,
  mem_bist_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   MAX_ERR   = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [DW-1:0] exp_q;
  logic [AW-1:0] cmp_addr_q;
  logic          cmp_vld_q;
  logic [AW:0]   err_d;
  logic          accept;
  logic          mismatch;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] s);
    return DW'(a) ^ s;
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    seed_d   = seed_q;
    accept   = 1'b0;
    mismatch = cmp_vld_q && (bus.rd_data != exp_q);
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = WRITE;
          addr_d  = '0;
          seed_d  = bus.seed;
        end
      end
      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) state_d = CHECK;
        else                     addr_d  = addr_q + AW'(1);
      end
      CHECK:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    err_d = bus.err_count;
    if (accept)                                 err_d = '0;
    else if (mismatch && bus.err_count != MAX_ERR) err_d = bus.err_count + (AW + 1)'(1);
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      seed_q        <= '0;
      exp_q         <= '0;
      cmp_addr_q    <= '0;
      cmp_vld_q     <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.rd_addr   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      seed_q        <= seed_d;
      exp_q         <= pattern(addr_q, seed_q);
      cmp_addr_q    <= addr_q;
      cmp_vld_q     <= (state_q == READ);
      bus.wr_en     <= (state_d == WRITE);
      if (state_d == WRITE) begin
        bus.wr_addr <= addr_d;
        bus.wr_data <= pattern(addr_d, seed_d);
      end
      if (state_d == READ) bus.rd_addr <= addr_d;
      bus.busy      <= (state_d inside {WRITE, READ, CHECK});
      bus.done      <= (state_d == DONE);
      bus.pass      <= (state_d == DONE) && (err_d == '0);
      bus.err_count <= err_d;
    end
  end

`ifdef MEM_BIST_ERR_LOG_EN
  // Only the first mismatch of a test is kept; the valid flag blocks later overwrites.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.first_err_addr <= '0;
      bus.first_err_data <= '0;
      bus.first_err_vld  <= 1'b0;
    end else if (accept) begin
      bus.first_err_addr <= '0;
      bus.first_err_data <= '0;
      bus.first_err_vld  <= 1'b0;
    end else if (mismatch && !bus.first_err_vld) begin
      bus.first_err_addr <= cmp_addr_q;
      bus.first_err_data <= bus.rd_data;
      bus.first_err_vld  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Directed bench for mem_bist_initiator: default-depth instance plus a DEPTH=20 instance.
module tb_mem_bist_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   ram_mode = 0;
  int   wr_cnt0 = 0, wr_cnt1 = 0;
  int   max_wr1 = -1, max_rd1 = -1, first_rd1 = 255;
  logic [5:0] data_at3 = '0;
  logic prev_wr1 = 1'b0;

  mem_bist_if #(.DW(6), .AW(5)) b0 ();
  mem_bist_if #(.DW(6), .AW(5)) b1 ();

  mem_bist_initiator #(.DW(6), .DEPTH(32), .AW(5)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mem_bist_initiator #(.DW(6), .DEPTH(20), .AW(5)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  logic [5:0] mem0 [32];
  logic [5:0] mem1 [32];

  // RAM models: mode 0 ideal, mode 1 inverts bit0 on reads of address 7, mode 2 reads all zero.
  always @(posedge clk) begin
    if (b0.wr_en) mem0[b0.wr_addr] <= b0.wr_data;
    case (ram_mode)
      1:       b0.rd_data <= mem0[b0.rd_addr] ^ {5'd0, (b0.rd_addr == 5'd7)};
      2:       b0.rd_data <= 6'd0;
      default: b0.rd_data <= mem0[b0.rd_addr];
    endcase
    if (b1.wr_en) mem1[b1.wr_addr] <= b1.wr_data;
    b1.rd_data <= mem1[b1.rd_addr];
  end

  always @(negedge clk) begin
    if (b0.wr_en) begin
      wr_cnt0++;
      if (b0.wr_addr == 5'd3) data_at3 = b0.wr_data;
    end
    if (b1.wr_en) begin
      wr_cnt1++;
      if (int'(b1.wr_addr) > max_wr1) max_wr1 = int'(b1.wr_addr);
    end
    if (int'(b1.rd_addr) > max_rd1) max_rd1 = int'(b1.rd_addr);
    if (prev_wr1 && !b1.wr_en && b1.busy) first_rd1 = int'(b1.rd_addr);
    prev_wr1 = b1.wr_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then counts busy cycles after the accept edge (bounded).
  task automatic applyStimulus(input bit sel, input logic [5:0] s, input bit disturb, output int cyc);
    logic st;
    @(negedge clk);
    if (sel) begin b1.seed = s; b1.start = 1'b1; end
    else     begin b0.seed = s; b0.start = 1'b1; end
    @(posedge clk);
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!(sel ? b1.busy : b0.busy)) break;
      cyc++;
      st = disturb && (cyc < 32 || cyc == 45);
      if (sel) b1.start = st; else b0.start = st;
    end
    b0.start = 1'b0;
    b1.start = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"},   32'(b0.wr_en),     32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(b0.wr_addr),   32'd0);
    checkOutput({tag, "_wr_data"}, 32'(b0.wr_data),   32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(b0.rd_addr),   32'd0);
    checkOutput({tag, "_busy"},    32'(b0.busy),      32'd0);
    checkOutput({tag, "_done"},    32'(b0.done),      32'd0);
    checkOutput({tag, "_pass"},    32'(b0.pass),      32'd0);
    checkOutput({tag, "_err"},     32'(b0.err_count), 32'd0);
  endtask

  initial begin
    int cyc;
    int w;
    b0.start = 1'b0; b0.seed = '0;
    b1.start = 1'b0; b1.seed = '0;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ideal RAM, seed 0x15
    w = wr_cnt0;
    applyStimulus(1'b0, 6'h15, 1'b0, cyc);
    checkOutput("t1_busy_cycles", 32'(cyc),            32'd65);
    checkOutput("t1_done",        32'(b0.done),        32'd1);
    checkOutput("t1_pass",        32'(b0.pass),        32'd1);
    checkOutput("t1_err",         32'(b0.err_count),   32'd0);
    checkOutput("t1_wdata_at3",   32'(data_at3),       32'h16);
    checkOutput("t1_write_count", 32'(wr_cnt0 - w),    32'd32);
    checkOutput("t1_wr_en_off",   32'(b0.wr_en),       32'd0);

    // start held through WRITE and re-pulsed in READ must be ignored
    applyStimulus(1'b0, 6'h15, 1'b1, cyc);
    checkOutput("t4_busy_cycles", 32'(cyc),      32'd65);
    checkOutput("t4_done",        32'(b0.done),  32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t4_done_held",   32'(b0.done),  32'd1);
    checkOutput("t4_busy_low",    32'(b0.busy),  32'd0);

    // Bit0 inverted at address 7
    ram_mode = 1;
    applyStimulus(1'b0, 6'h00, 1'b0, cyc);
    checkOutput("t2_err",  32'(b0.err_count), 32'd1);
    checkOutput("t2_pass", 32'(b0.pass),      32'd0);
    checkOutput("t2_done", 32'(b0.done),      32'd1);
`ifdef MEM_BIST_ERR_LOG_EN
    checkOutput("t2_first_addr", 32'(b0.first_err_addr), 32'd7);
    checkOutput("t2_first_data", 32'(b0.first_err_data), 32'h06);
    checkOutput("t2_first_vld",  32'(b0.first_err_vld),  32'd1);
`endif

    // rd_data stuck at zero, seed 0x3F: every compare fails
    ram_mode = 2;
    applyStimulus(1'b0, 6'h3F, 1'b0, cyc);
    checkOutput("t6_err",  32'(b0.err_count), 32'd32);
    checkOutput("t6_pass", 32'(b0.pass),      32'd0);
    ram_mode = 0;
    @(negedge clk);
    b0.seed = 6'h3F; b0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    checkOutput("t6_restart_err",  32'(b0.err_count), 32'd0);
    checkOutput("t6_restart_done", 32'(b0.done),      32'd0);
    checkOutput("t6_restart_busy", 32'(b0.busy),      32'd1);
`ifdef MEM_BIST_ERR_LOG_EN
    checkOutput("t6_restart_vld",  32'(b0.first_err_vld), 32'd0);
`endif
    for (int i = 0; i < 200 && b0.busy; i++) @(negedge clk);
    checkOutput("t6_rerun_done", 32'(b0.done), 32'd1);
    checkOutput("t6_rerun_pass", 32'(b0.pass), 32'd1);

    // Reset during WRITE cycle 10
    @(negedge clk);
    b0.seed = 6'h2A; b0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("t3_pre_wr_en", 32'(b0.wr_en), 32'd1);
    rst = 1'b1;
    #1;
    checkResetOutputs("t3_rst");
    w = wr_cnt0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t3_no_wr_en", 32'(wr_cnt0 - w), 32'd0);
    checkOutput("t3_idle_busy", 32'(b0.busy),    32'd0);
    applyStimulus(1'b0, 6'h2A, 1'b0, cyc);
    checkOutput("t3_busy_cycles", 32'(cyc),     32'd65);
    checkOutput("t3_pass",        32'(b0.pass), 32'd1);

    // DEPTH=20 instance
    w = wr_cnt1;
    applyStimulus(1'b1, 6'h0C, 1'b0, cyc);
    checkOutput("t5_busy_cycles", 32'(cyc),         32'd41);
    checkOutput("t5_write_count", 32'(wr_cnt1 - w), 32'd20);
    checkOutput("t5_max_wr_addr", 32'(max_wr1),     32'd19);
    checkOutput("t5_max_rd_addr", 32'(max_rd1),     32'd19);
    checkOutput("t5_first_rd",    32'(first_rd1),   32'd0);
    checkOutput("t5_pass",        32'(b1.pass),     32'd1);
    checkOutput("t5_err",         32'(b1.err_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
